// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter: 16-bit left/right samples, one-entry holding register,
// 32 BCK periods per frame with the standard one-bit delay after each LRCK edge.
module i2s_audio_tx #(
  parameter int unsigned BCK_HALF = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(BCK_HALF - 1);

  logic [7:0]  div_q, div_d;
  logic        bck_q, bck_d;
  logic [4:0]  k_q, k_d;
  logic        lrck_q, lrck_d;
  logic        data_q, data_d;
  logic        fs_q, fs_d;
  logic        ur_q, ur_d;
  logic [15:0] act_l_q, act_l_d;
  logic [15:0] act_r_q, act_r_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;

  logic        div_wrap;
  logic        shift_evt;
  logic        frame_evt;
  logic        accept;
  logic [3:0]  bit_idx;

  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    shift_evt = div_wrap && bck_q;
    frame_evt = shift_evt && (k_q == 5'd0);
    accept    = in_valid && !hold_full_q;
    // L[16-k] for k=1..16 and R[32-k] for k=17..31 both reduce to (-k) mod 16.
    bit_idx   = 4'(5'd0 - k_q);
  end

  always_comb begin
    // NOTE: every next-state value starts from its hold value so no latch is inferred.
    div_d       = div_wrap ? 8'd0 : div_q + 8'd1;
    bck_d       = div_wrap ? !bck_q : bck_q;
    k_d         = k_q;
    lrck_d      = lrck_q;
    data_d      = data_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;

    if (shift_evt) begin
      k_d    = k_q + 5'd1;
      lrck_d = k_q[4];
      if (k_q == 5'd0)       data_d = act_r_q[0];
      else if (k_q <= 5'd16) data_d = act_l_q[bit_idx];
      else                   data_d = act_r_q[bit_idx];
    end

    // A pair accepted on a frame boundary with an empty register waits for the next frame.
    if (frame_evt) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
        fs_d        = 1'b1;
      end else begin
        act_l_d = 16'd0;
        act_r_d = 16'd0;
        ur_d    = 1'b1;
      end
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = left_in;
      hold_r_d    = right_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all decisions live in the _d logic.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q       <= 8'd0;
      bck_q       <= 1'b0;
      k_q         <= 5'd0;
      lrck_q      <= 1'b1;
      data_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      act_l_q     <= 16'd0;
      act_r_q     <= 16'd0;
      hold_full_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      bck_q       <= bck_d;
      k_q         <= k_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      hold_full_q <= hold_full_d;
    end
  end

  // NOTE: holding data needs no reset; it is never observed while hold_full_q is clear.
  always_ff @(posedge clk_sys) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign in_ready    = !hold_full_q;
  assign i2s_bck     = bck_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_data    = data_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: two instances (BCK_HALF=2 and 3) checked every cycle against
// a timeline model derived from cycles-since-reset, plus hand-computed spot values.
module tb_i2s_audio_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in [2];
  logic        vld    [2];
  logic [15:0] lin    [2];
  logic [15:0] rin    [2];
  logic        rdy    [2];
  logic        bck    [2];
  logic        lrck   [2];
  logic        dat    [2];
  logic        fs     [2];
  logic        ur     [2];

  i2s_audio_tx #(.BCK_HALF(2)) u_dut0 (
    .clk_sys(clk), .reset(rst_in[0]), .left_in(lin[0]), .right_in(rin[0]),
    .in_valid(vld[0]), .in_ready(rdy[0]), .i2s_bck(bck[0]), .i2s_lrck(lrck[0]),
    .i2s_data(dat[0]), .frame_start(fs[0]), .underrun(ur[0])
  );

  i2s_audio_tx #(.BCK_HALF(3)) u_dut1 (
    .clk_sys(clk), .reset(rst_in[1]), .left_in(lin[1]), .right_in(rin[1]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .i2s_bck(bck[1]), .i2s_lrck(lrck[1]),
    .i2s_data(dat[1]), .frame_start(fs[1]), .underrun(ur[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit done0 = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: n = rising edges since reset; frames record what each frame plays.
  int          n_m     [2];
  bit          mvalid  [2];
  bit          full_m  [2];
  logic [15:0] hl_m    [2];
  logic [15:0] hr_m    [2];
  logic [15:0] fl_m    [2][64];
  logic [15:0] fr_m    [2][64];
  bit          fmute_m [2][64];

  function automatic int bh(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic model_step(input int i);
    bit acc;
    int m, f;
    if (rst_in[i]) begin
      n_m[i]    = 0;
      full_m[i] = 1'b0;
      mvalid[i] = 1'b1;
      return;
    end
    if (!mvalid[i]) return;
    acc = vld[i] && !full_m[i];
    n_m[i]++;
    if (n_m[i] % (2 * bh(i)) == 0) begin
      m = n_m[i] / (2 * bh(i));
      if ((m - 1) % 32 == 0) begin
        f = ((m - 1) / 32) % 64;
        fmute_m[i][f] = !full_m[i];
        fl_m[i][f]    = full_m[i] ? hl_m[i] : 16'd0;
        fr_m[i][f]    = full_m[i] ? hr_m[i] : 16'd0;
        full_m[i]     = 1'b0;
      end
    end
    if (acc) begin
      full_m[i] = 1'b1;
      hl_m[i]   = lin[i];
      hr_m[i]   = rin[i];
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic expect_out(input int i, output logic e_bck, output logic e_lrck,
                            output logic e_dat, output logic e_fs, output logic e_ur,
                            output logic e_rdy);
    int n, b, m, k, f, fi;
    n      = n_m[i];
    b      = bh(i);
    m      = n / (2 * b);
    e_bck  = ((n / b) % 2) == 1;
    e_rdy  = !full_m[i];
    e_fs   = 1'b0;
    e_ur   = 1'b0;
    e_lrck = 1'b1;
    e_dat  = 1'b0;
    if (m > 0) begin
      k      = (m - 1) % 32;
      f      = (m - 1) / 32;
      fi     = f % 64;
      e_lrck = (k >= 16);
      if (k == 0) begin
        e_dat = (f == 0) ? 1'b0 : fr_m[i][(f - 1) % 64][0];
        if (n % (2 * b) == 0) begin
          e_fs = !fmute_m[i][fi];
          e_ur = fmute_m[i][fi];
        end
      end else if (k <= 16) begin
        e_dat = fl_m[i][fi][16 - k];
      end else begin
        e_dat = fr_m[i][fi][32 - k];
      end
    end
  endtask

  always @(negedge clk) begin
    logic e_bck, e_lrck, e_dat, e_fs, e_ur, e_rdy;
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        expect_out(i, e_bck, e_lrck, e_dat, e_fs, e_ur, e_rdy);
        check($sformatf("u%0d.i2s_bck n=%0d", i, n_m[i]), 16'(bck[i]), 16'(e_bck));
        check($sformatf("u%0d.i2s_lrck n=%0d", i, n_m[i]), 16'(lrck[i]), 16'(e_lrck));
        check($sformatf("u%0d.i2s_data n=%0d", i, n_m[i]), 16'(dat[i]), 16'(e_dat));
        check($sformatf("u%0d.frame_start n=%0d", i, n_m[i]), 16'(fs[i]), 16'(e_fs));
        check($sformatf("u%0d.underrun n=%0d", i, n_m[i]), 16'(ur[i]), 16'(e_ur));
        check($sformatf("u%0d.in_ready n=%0d", i, n_m[i]), 16'(rdy[i]), 16'(e_rdy));
      end
    end
  end

  task automatic run_to(input int target);
    int g = 0;
    while (n_m[0] < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("reach_n", 16'(n_m[0]), 16'(target));
  endtask

  task automatic reset0();
    rst_in[0] = 1'b1;
    vld[0]    = 1'b0;
    repeat (2) @(negedge clk);
    rst_in[0] = 1'b0;
  endtask

  task automatic push0(input logic [15:0] l, input logic [15:0] r);
    int g = 0;
    while (!rdy[0] && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", 16'(rdy[0]), 16'd1);
    vld[0] = 1'b1;
    lin[0] = l;
    rin[0] = r;
    @(negedge clk);
    vld[0] = 1'b0;
    lin[0] = 16'hDEAD;
    rin[0] = 16'hBEEF;
  endtask

  logic [15:0] v3_vals [8] = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF,
                              16'h1234, 16'hFEDC, 16'h0F0F, 16'h5555};

  // Instance 0 (BCK_HALF=2): directed scenarios.
  initial begin
    rst_in[0] = 1'b1;
    vld[0]    = 1'b0;
    lin[0]    = 16'd0;
    rin[0]    = 16'd0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 16'(rdy[0]), 16'd1);
    check("rst lrck", 16'(lrck[0]), 16'd1);
    check("rst data", 16'(dat[0]), 16'd0);
    check("rst bck", 16'(bck[0]), 16'd0);

    // Single pair, then input changes that must not reach the frame.
    rst_in[0] = 1'b0;
    vld[0]    = 1'b1;
    lin[0]    = 16'hA5C3;
    rin[0]    = 16'h0F81;
    @(negedge clk);
    check("v1 in_ready after accept", 16'(rdy[0]), 16'd0);
    vld[0] = 1'b0;
    lin[0] = 16'h1111;
    rin[0] = 16'h2222;
    run_to(4);
    check("v1 k0 frame_start", 16'(fs[0]), 16'd1);
    check("v1 k0 lrck", 16'(lrck[0]), 16'd0);
    check("v1 k0 data", 16'(dat[0]), 16'd0);
    run_to(8);
    check("v1 k1 data L15", 16'(dat[0]), 16'd1);
    run_to(12);
    check("v1 k2 data L14", 16'(dat[0]), 16'd0);
    run_to(68);
    check("v1 k16 lrck", 16'(lrck[0]), 16'd1);
    check("v1 k16 data L0", 16'(dat[0]), 16'd1);
    run_to(72);
    check("v1 k17 data R15", 16'(dat[0]), 16'd0);
    run_to(128);
    check("v1 k31 data R1", 16'(dat[0]), 16'd0);
    run_to(132);
    check("v1 next k0 data R0", 16'(dat[0]), 16'd1);
    check("v1 next k0 underrun", 16'(ur[0]), 16'd1);
    run_to(260);

    // Idle: muted frames with an underrun each frame.
    reset0();
    run_to(260);
    check("v2 underrun frame2", 16'(ur[0]), 16'd1);
    run_to(392);

    // One pair per frame, no underrun expected.
    for (int j = 0; j < 8; j++) push0(v3_vals[j], {v3_vals[j][7:0], v3_vals[j][15:8]});
    run_to(n_m[0] + 300);

    // Pair arriving exactly on a k=0 event with an empty register.
    reset0();
    run_to(3);
    vld[0] = 1'b1;
    lin[0] = 16'h1357;
    rin[0] = 16'h2468;
    @(negedge clk);
    vld[0] = 1'b0;
    check("v4 k0 underrun", 16'(ur[0]), 16'd1);
    check("v4 k0 frame_start", 16'(fs[0]), 16'd0);
    check("v4 pair held", 16'(rdy[0]), 16'd0);
    run_to(132);
    check("v4 next frame_start", 16'(fs[0]), 16'd1);
    run_to(136);
    check("v4 k1 data L15", 16'(dat[0]), 16'd0);

    // Reset mid-frame with a held pair; the pair must never play.
    push0(16'hABCD, 16'h4321);
    run_to(212);
    rst_in[0] = 1'b1;
    @(negedge clk);
    check("v5 rst in_ready", 16'(rdy[0]), 16'd1);
    check("v5 rst lrck", 16'(lrck[0]), 16'd1);
    check("v5 rst data", 16'(dat[0]), 16'd0);
    @(negedge clk);
    rst_in[0] = 1'b0;
    run_to(4);
    check("v5 after rst underrun", 16'(ur[0]), 16'd1);
    run_to(300);

    done0 = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Instance 1 (BCK_HALF=3): back-to-back valid with changing data.
  initial begin
    int g = 0;
    rst_in[1] = 1'b1;
    vld[1]    = 1'b1;
    lin[1]    = 16'h0123;
    rin[1]    = 16'hC0DE;
    repeat (3) @(negedge clk);
    rst_in[1] = 1'b0;
    while (!done0 && g < 20000) begin
      @(negedge clk);
      g++;
      if (n_m[1] == 1) check("v6 in_ready n1", 16'(rdy[1]), 16'd0);
      if (n_m[1] == 2) check("v6 bck n2", 16'(bck[1]), 16'd0);
      if (n_m[1] == 3) check("v6 bck n3", 16'(bck[1]), 16'd1);
      if (n_m[1] == 6) begin
        check("v6 bck n6", 16'(bck[1]), 16'd0);
        check("v6 frame_start n6", 16'(fs[1]), 16'd1);
        check("v6 in_ready n6", 16'(rdy[1]), 16'd1);
      end
      if (n_m[1] == 7) check("v6 in_ready n7", 16'(rdy[1]), 16'd0);
      lin[1] = lin[1] + 16'h1357;
      rin[1] = (rin[1] ^ 16'hA5A5) + 16'h0101;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
